mem_request_arbiter: RTL and testbench

- Single-port memory arbiter that feeds the pipeline hazard logic its ihit/dhit strobes and load data.
- Serialises instruction-fetch and data (load/store) requests onto one wait-stated RAM port; data has priority over fetch.
- Hit strobes are single-cycle and registered, so the hazard logic sees a glitch-free hit exactly once per completed access.
- Detects stuck or errored RAM transactions and raises a sticky error.

---
 rtl/mem_request_arbiter_if.sv | 15 +
 rtl/mem_request_arbiter.sv | 95 +++++++++
 tb/tb_mem_request_arbiter.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/mem_request_arbiter_if.sv
// mem_request_arbiter_if: fetch/data request, hit strobe and RAM port bundle
interface mem_request_arbiter_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
  logic              iREN, dREN, dWEN, ihit, dhit, ramREN, ramWEN, busy, mem_err;
  logic [ADDR_W-1:0] iaddr, daddr, ramaddr;
  logic [DATA_W-1:0] dstore, iload, dload, ramstore, ramload;
  logic [1:0]        ramstate;
  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output ihit, dhit, iload, dload, ramREN, ramWEN, ramaddr, ramstore, busy, mem_err
  );
  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  ihit, dhit, iload, dload, ramREN, ramWEN, ramaddr, ramstore, busy, mem_err
  );
endinterface

// File: rtl/mem_request_arbiter.sv
// mem_request_arbiter: serialises fetch and data requests onto one wait-stated RAM port
module mem_request_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input logic CLK,
  input logic nRST,
  mem_request_arbiter_if.slave bus
);
  localparam logic [2:0] IDLE = 3'd0, DATA = 3'd1, INSTR = 3'd2, DDONE = 3'd3, IDONE = 3'd4, ERR = 3'd5;
  localparam logic [1:0] ACCESS = 2'd2, ERROR = 2'd3;
  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d, iload_q, iload_d, dload_q, dload_d;
  logic              wr_q, wr_d, ihit_q, ihit_d, dhit_q, dhit_d;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wr_d    = wr_q;
    iload_d = iload_q;
    dload_d = dload_q;
    ihit_d  = 1'b0;
    dhit_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.dREN || bus.dWEN) begin
          state_d = DATA;
          addr_d  = bus.daddr;
          data_d  = bus.dstore;
          wr_d    = bus.dWEN;
          cnt_d   = '0;
        end else if (bus.iREN) begin
          state_d = INSTR;
          addr_d  = bus.iaddr;
          cnt_d   = '0;
        end
      end
      DATA, INSTR: begin
        if (bus.ramstate == ACCESS) begin
          state_d = (state_q == DATA) ? DDONE : IDONE;
          if (state_q == DATA) begin
            dload_d = wr_q ? dload_q : bus.ramload;
            dhit_d  = bus.dREN || bus.dWEN;
          end else begin
            iload_d = bus.ramload;
            ihit_d  = bus.iREN && (bus.iaddr == addr_q);
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (bus.ramstate == ERROR || cnt_d == CNT_W'(TIMEOUT)) state_d = ERR;
        end
      end
      DDONE, IDONE: state_d = IDLE;
      default: state_d = state_q;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      iload_q <= '0;
      dload_q <= '0;
      ihit_q  <= 1'b0;
      dhit_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      iload_q <= iload_d;
      dload_q <= dload_d;
      ihit_q  <= ihit_d;
      dhit_q  <= dhit_d;
    end
  end
  assign bus.ramREN   = (state_q == DATA && !wr_q) || state_q == INSTR;
  assign bus.ramWEN   = state_q == DATA && wr_q;
  assign bus.ramaddr  = (state_q == DATA || state_q == INSTR) ? addr_q : '0;
  assign bus.ramstore = (state_q == DATA) ? data_q : '0;
  assign bus.ihit     = ihit_q;
  assign bus.dhit     = dhit_q;
  assign bus.iload    = iload_q;
  assign bus.dload    = dload_q;
  assign bus.busy     = state_q != IDLE && state_q != ERR;
  assign bus.mem_err  = state_q == ERR;
endmodule

// File: tb/tb_mem_request_arbiter.sv
// tb_mem_request_arbiter: directed scoreboard bench for mem_request_arbiter
module tb_mem_request_arbiter;
  typedef struct packed {logic d; logic cd; logic [31:0] v;} hit_t;
  typedef struct packed {logic r; logic w; logic [31:0] a; logic [31:0] s;} ram_t;
  logic CLK = 1'b0;
  logic nRST;
  int   tests = 0;
  int   fails = 0;
  hit_t hit_q[$];
  ram_t ram_q[$];
  logic prev_strobe = 1'b0;
  mem_request_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  mem_request_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4), .CNT_W(8)) dut (
    .CLK(CLK), .nRST(nRST), .bus(bus)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask
  task automatic exp_hit(input logic d, input logic cd, input logic [31:0] v);
    hit_q.push_back('{d: d, cd: cd, v: v});
  endtask
  task automatic exp_ram(input logic w, input logic [31:0] a, input logic [31:0] s);
    ram_q.push_back('{r: !w, w: w, a: a, s: w ? s : 32'h0});
  endtask
  always @(negedge CLK) begin
    hit_t h;
    ram_t r;
    logic strobe;
    if (nRST) begin
      if (bus.ihit || bus.dhit) begin
        if (hit_q.size() == 0) chk("unexpected_hit", {70'h0, bus.dhit, bus.ihit}, 72'h0);
        else begin
          h = hit_q.pop_front();
          chk("hit", {bus.dhit, bus.ihit, h.cd ? (bus.dhit ? bus.dload : bus.iload) : 32'h0},
                     {h.d, !h.d, h.cd ? h.v : 32'h0});
        end
      end
      strobe = bus.ramREN || bus.ramWEN;
      if (strobe && !prev_strobe) begin
        if (ram_q.size() == 0) chk("unexpected_ram", {38'h0, bus.ramREN, bus.ramWEN, bus.ramaddr}, 72'h0);
        else begin
          r = ram_q.pop_front();
          chk("ram", {bus.ramREN, bus.ramWEN, bus.ramaddr, bus.ramWEN ? bus.ramstore : 32'h0}, r);
        end
      end
      prev_strobe = strobe;
    end else prev_strobe = 1'b0;
  end
  initial begin
    nRST = 1'b0;
    bus.iREN = 0; bus.iaddr = 0; bus.dREN = 1; bus.dWEN = 0; bus.daddr = 32'h40;
    bus.dstore = 0; bus.ramload = 0; bus.ramstate = 2'd0;
    cyc(); cyc();
    chk("rst_outs", {62'h0, bus.ihit, bus.dhit, bus.ramREN, bus.ramWEN, bus.busy, bus.mem_err, 4'h0}, 72'h0);
    chk("rst_ramaddr", {40'h0, bus.ramaddr}, 72'h0);
    chk("rst_loads", {8'h0, bus.iload, bus.dload}, 72'h0);
    exp_ram(0, 32'h40, 0);
    exp_hit(1, 1, 32'h1111);
    nRST = 1'b1;
    cyc();
    chk("rel_ramREN", {71'h0, bus.ramREN}, 72'h1);
    chk("rel_ramaddr", {40'h0, bus.ramaddr}, 72'h40);
    bus.ramstate = 2'd2; bus.ramload = 32'h1111;
    cyc();
    bus.dREN = 0; bus.ramstate = 2'd0;
    cyc(); cyc();
    bus.dREN = 1; bus.daddr = 32'h100;
    exp_ram(0, 32'h100, 0);
    exp_hit(1, 1, 32'hDEADBEEF);
    cyc();
    bus.ramstate = 2'd1;
    cyc(); cyc();
    bus.ramstate = 2'd2; bus.ramload = 32'hDEADBEEF;
    cyc();
    chk("read_latency_dhit", {71'h0, bus.dhit}, 72'h1);
    bus.dREN = 0; bus.ramstate = 2'd0;
    cyc();
    chk("read_dhit_once", {71'h0, bus.dhit}, 72'h0);
    chk("read_dload_hold", {40'h0, bus.dload}, 72'hDEADBEEF);
    cyc();
    bus.iREN = 1; bus.iaddr = 32'h400; bus.dWEN = 1; bus.daddr = 32'h8; bus.dstore = 32'h55;
    exp_ram(1, 32'h8, 32'h55);
    exp_hit(1, 0, 0);
    exp_ram(0, 32'h400, 0);
    exp_hit(0, 1, 32'hCAFE0000);
    cyc();
    bus.ramstate = 2'd2;
    cyc();
    bus.dWEN = 0; bus.ramstate = 2'd0;
    cyc(); cyc();
    bus.ramstate = 2'd2; bus.ramload = 32'hCAFE0000;
    cyc();
    bus.iREN = 0; bus.ramstate = 2'd0;
    cyc(); cyc();
    bus.iREN = 1; bus.iaddr = 32'h500;
    exp_ram(0, 32'h500, 0);
    exp_hit(0, 1, 32'h12345678);
    exp_ram(0, 32'h600, 0);
    exp_hit(1, 1, 32'h9ABC);
    cyc();
    bus.ramstate = 2'd1; bus.dREN = 1; bus.daddr = 32'h600;
    cyc(); cyc();
    bus.ramstate = 2'd2; bus.ramload = 32'h12345678;
    cyc();
    bus.iREN = 0; bus.ramstate = 2'd0;
    cyc(); cyc();
    bus.ramstate = 2'd2; bus.ramload = 32'h9ABC;
    cyc();
    bus.dREN = 0; bus.ramstate = 2'd0;
    cyc(); cyc();
    bus.iREN = 1; bus.iaddr = 32'h200;
    exp_ram(0, 32'h200, 0);
    exp_ram(0, 32'h300, 0);
    exp_hit(0, 1, 32'h3333);
    cyc();
    bus.ramstate = 2'd1; bus.iaddr = 32'h300;
    cyc();
    bus.ramstate = 2'd2; bus.ramload = 32'h2222;
    cyc();
    chk("stale_ihit", {71'h0, bus.ihit}, 72'h0);
    chk("stale_iload", {40'h0, bus.iload}, 72'h2222);
    bus.ramstate = 2'd0;
    cyc(); cyc();
    bus.ramstate = 2'd2; bus.ramload = 32'h3333;
    cyc();
    bus.iREN = 0; bus.ramstate = 2'd0;
    cyc(); cyc();
    bus.dWEN = 1; bus.daddr = 32'h20; bus.dstore = 32'h77;
    exp_ram(1, 32'h20, 32'h77);
    cyc();
    bus.dWEN = 0; bus.ramstate = 2'd1;
    cyc();
    chk("withdrawn_wen", {71'h0, bus.ramWEN}, 72'h1);
    bus.ramstate = 2'd2;
    cyc();
    chk("withdrawn_dhit", {71'h0, bus.dhit}, 72'h0);
    bus.ramstate = 2'd0;
    cyc(); cyc();
    bus.dREN = 1; bus.daddr = 32'h44;
    exp_ram(0, 32'h44, 0);
    cyc();
    bus.ramstate = 2'd1;
    cyc(); cyc(); cyc();
    chk("timeout_not_yet", {70'h0, bus.mem_err, bus.busy}, 72'h1);
    cyc();
    chk("timeout_err", {69'h0, bus.mem_err, bus.busy, bus.ramREN}, 72'h4);
    bus.iREN = 1; bus.iaddr = 32'h700;
    cyc(); cyc(); cyc();
    chk("err_sticky", {68'h0, bus.mem_err, bus.ramREN, bus.ramWEN, bus.ihit || bus.dhit}, 72'h8);
    nRST = 0; bus.iREN = 0; bus.dREN = 0; bus.ramstate = 2'd0;
    cyc();
    chk("err_cleared", {71'h0, bus.mem_err}, 72'h0);
    nRST = 1;
    cyc();
    bus.dREN = 1; bus.daddr = 32'h48;
    exp_ram(0, 32'h48, 0);
    cyc();
    bus.ramstate = 2'd3;
    cyc();
    chk("ramerror_err", {70'h0, bus.mem_err, bus.ramREN}, 72'h2);
    bus.dREN = 0; nRST = 0; bus.ramstate = 2'd0;
    cyc();
    nRST = 1;
    cyc(); cyc();
    chk("hit_q_empty", 72'(hit_q.size()), 72'h0);
    chk("ram_q_empty", 72'(ram_q.size()), 72'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
